// File: rtl/usb_tx_pkg.sv
// Shared types for the transmit scheduler: requester count, index type, FSM states.
package usb_tx_pkg;

   localparam int NREQ = 3;

   typedef logic [$clog2(NREQ)-1:0] idx_t;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      COMPLETE,
      ABORT
   } state_e;

   function automatic idx_t onehot_idx(input logic [NREQ-1:0] oh);
      idx_t r;
      r = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) r = idx_t'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/tx_sched_rr_pick3.sv
// Combinational round-robin picker: search starts one past the last winner and
// returns a one-hot winner (all zero when nobody requests).
module rr_pick3
   import usb_tx_pkg::*;
(
   input  logic [NREQ-1:0] req_i,
   input  idx_t            last_winner_i,
   output logic [NREQ-1:0] winner_o
);

   idx_t cand [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand[gi] = idx_t'((int'(last_winner_i) + gi + 1) % NREQ);
      end
   endgenerate

   // Walk from lowest priority to highest so the nearest candidate overrides.
   always_comb begin
      winner_o = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[cand[k]]) begin
            winner_o          = '0;
            winner_o[cand[k]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_sched.sv
// Transmit scheduler: round-robin grant of one of three requesters, launch pulse,
// wait for transmitter ack with timeout, then done/err pulse back to the winner.
module tx_sched
   import usb_tx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0][63:0] req_data,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [NREQ-1:0]       err,
   output logic [63:0]           trans_data,
   output logic                  trans_data_ready,
   input  logic                  handshake_ack,
   output logic                  busy
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] SAT  = '1;

   state_e          state_q;
   logic [NREQ-1:0] gnt_q, done_q, err_q;
   logic [63:0]     data_q;
   logic            tdr_q;
   logic [CW-1:0]   cnt_q;
   idx_t            last_q;

   logic [NREQ-1:0] pick_d;
   logic [63:0]     data_d;

   rr_pick3 u_pick (
      .req_i         (req),
      .last_winner_i (last_q),
      .winner_o      (pick_d)
   );

   always_comb begin
      data_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_d[i]) data_d = req_data[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
         data_q  <= '0;
         tdr_q   <= 1'b0;
         cnt_q   <= '0;
         last_q  <= idx_t'(NREQ - 1);
      end else begin
         tdr_q  <= 1'b0;
         done_q <= '0;
         err_q  <= '0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  gnt_q   <= pick_d;
                  data_q  <= data_d;
                  tdr_q   <= 1'b1;
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // Ack takes priority over the terminal count.
               if (handshake_ack) begin
                  done_q  <= gnt_q;
                  state_q <= COMPLETE;
               end else if (cnt_q == TERM) begin
                  err_q   <= gnt_q;
                  state_q <= ABORT;
               end else if (cnt_q != SAT) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            COMPLETE, ABORT: begin
               last_q  <= onehot_idx(gnt_q);
               gnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt              = gnt_q;
   assign done             = done_q;
   assign err              = err_q;
   assign trans_data       = data_q;
   assign trans_data_ready = tdr_q;
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched with an 8-cycle timeout.
module tb_tx_sched;

   logic             clk;
   logic             rst;
   logic [2:0]       req;
   logic [2:0][63:0] req_data;
   logic [2:0]       gnt, done, err;
   logic [63:0]      trans_data;
   logic             trans_data_ready;
   logic             handshake_ack;
   logic             busy;

   int n_pass  = 0;
   int n_total = 0;

   tx_sched #(.TIMEOUT_CYCLES(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .req              (req),
      .req_data         (req_data),
      .gnt              (gnt),
      .done             (done),
      .err              (err),
      .trans_data       (trans_data),
      .trans_data_ready (trans_data_ready),
      .handshake_ack    (handshake_ack),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      rst           = 1'b1;
      req           = '0;
      req_data      = '0;
      handshake_ack = 1'b0;
      tick();
      tick();
      chk("rst_gnt",  64'(gnt), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_err",  64'(err), 64'h0);
      chk("rst_data", trans_data, 64'h0);
      chk("rst_tdr",  64'(trans_data_ready), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      rst = 1'b0;
      tick();
      chk("idle_noreq_gnt", 64'(gnt), 64'h0);

      // Single requester 1, ack five cycles after launch.
      req         = 3'b010;
      req_data[1] = 64'hDEADBEEF_00000001;
      tick();
      chk("t1_gnt",  64'(gnt), 64'h2);
      chk("t1_tdr",  64'(trans_data_ready), 64'h1);
      chk("t1_data", trans_data, 64'hDEADBEEF_00000001);
      chk("t1_busy", 64'(busy), 64'h1);
      req = 3'b000;
      tick();
      chk("t1_tdr_pulse", 64'(trans_data_ready), 64'h0);
      for (int i = 0; i < 4; i++) tick();
      chk("t1_wait_done", 64'(done), 64'h0);
      handshake_ack = 1'b1;
      tick();
      handshake_ack = 1'b0;
      chk("t1_done", 64'(done), 64'h2);
      chk("t1_data_hold", trans_data, 64'hDEADBEEF_00000001);
      tick();
      chk("t1_done_pulse", 64'(done), 64'h0);
      chk("t1_gnt_clr", 64'(gnt), 64'h0);
      chk("t1_busy_low", 64'(busy), 64'h0);

      // Fresh reset, then all three request continuously with ack always high.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_data[0]   = 64'hA0;
      req_data[1]   = 64'hA1;
      req_data[2]   = 64'hA2;
      req           = 3'b111;
      handshake_ack = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("rr%0d_gnt", k), 64'(gnt), 64'(3'b001 << (k % 3)));
         chk($sformatf("rr%0d_data", k), trans_data, 64'hA0 + 64'(k % 3));
         tick();
         tick();
         chk($sformatf("rr%0d_done", k), 64'(done), 64'(3'b001 << (k % 3)));
         tick();
         chk($sformatf("rr%0d_idle_gnt", k), 64'(gnt), 64'h0);
      end
      req           = 3'b000;
      handshake_ack = 1'b0;
      tick();

      // Requester 2 with no ack: err exactly 8 cycles after WAIT entry.
      req         = 3'b100;
      req_data[2] = 64'hC2;
      tick();
      chk("t3_gnt", 64'(gnt), 64'h4);
      req = 3'b000;
      tick();
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk($sformatf("t3_noerr%0d", i), 64'(err), 64'h0);
      end
      tick();
      chk("t3_err",  64'(err), 64'h4);
      chk("t3_done", 64'(done), 64'h0);
      tick();
      chk("t3_err_pulse", 64'(err), 64'h0);
      chk("t3_done_after", 64'(done), 64'h0);
      chk("t3_busy_low", 64'(busy), 64'h0);

      // Ack arrives on the terminal-count cycle: completion wins.
      req         = 3'b001;
      req_data[0] = 64'hB0;
      tick();
      chk("t4_gnt", 64'(gnt), 64'h1);
      req = 3'b000;
      tick();
      for (int i = 0; i < 7; i++) tick();
      handshake_ack = 1'b1;
      tick();
      handshake_ack = 1'b0;
      chk("t4_done", 64'(done), 64'h1);
      chk("t4_err",  64'(err), 64'h0);
      tick();
      chk("t4_err_after", 64'(err), 64'h0);

      // Reset while waiting on requester 0.
      req = 3'b001;
      tick();
      req = 3'b000;
      tick();
      chk("t5_gnt_wait",  64'(gnt), 64'h1);
      chk("t5_busy_wait", 64'(busy), 64'h1);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_gnt",  64'(gnt), 64'h0);
      chk("t5_async_busy", 64'(busy), 64'h0);
      chk("t5_async_data", trans_data, 64'h0);
      tick();
      rst           = 1'b0;
      handshake_ack = 1'b1;
      tick();
      tick();
      chk("t5_no_done", 64'(done), 64'h0);
      chk("t5_no_err",  64'(err), 64'h0);
      chk("t5_ack_ignored_busy", 64'(busy), 64'h0);
      req_data[0] = 64'hE0;
      req_data[1] = 64'hE1;
      req         = 3'b011;
      tick();
      chk("t5_first_gnt", 64'(gnt), 64'h1);
      tick();
      tick();
      chk("t5_first_done", 64'(done), 64'h1);
      tick();
      tick();
      chk("t5_second_gnt", 64'(gnt), 64'h2);
      chk("t5_second_data", trans_data, 64'hE1);
      req = 3'b000;
      tick();
      tick();
      chk("t5_second_done", 64'(done), 64'h2);
      handshake_ack = 1'b0;
      tick();

      // Requester 0 drops request and changes payload after grant.
      req         = 3'b001;
      req_data[0] = 64'h1111_2222_3333_4444;
      tick();
      chk("t6_gnt", 64'(gnt), 64'h1);
      req         = 3'b000;
      req_data[0] = 64'h5555_6666_7777_8888;
      tick();
      chk("t6_data_wait", trans_data, 64'h1111_2222_3333_4444);
      handshake_ack = 1'b1;
      tick();
      handshake_ack = 1'b0;
      chk("t6_done", 64'(done), 64'h1);
      chk("t6_data_done", trans_data, 64'h1111_2222_3333_4444);
      tick();
      chk("t6_data_idle", trans_data, 64'h1111_2222_3333_4444);
      chk("t6_done_pulse", 64'(done), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
